lstm_seq_core: RTL and testbench

Stateful, parametrised successor to the fixed 4-step stateless LSTM pipeline. It runs one scalar LSTM cell over an input stream of programmable length (1..SEQ_LEN_MAX), one time step per accepted input sample. Inputs arrive on a valid/ready handshake and each step's h/c is emitted on one. Final h/c is retained, so a later sequence can continue from it; this supports chunked sequences longer than SEQ_LEN_MAX.

---
 rtl/lstm_pkg.sv | 49 ++++
 rtl/lstm_cell_step.sv | 78 +++++++
 rtl/lstm_seq_core.sv | 164 ++++++++++++++++
 tb/tb_lstm_seq_core.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Shared fixed-point types, constants and activation helpers for the scalar LSTM core.
// Data format is signed Q(WIDTH-FRAC-1).FRAC; products and sums run in acc_t before saturation.
package lstm_pkg;
  localparam int WIDTH = 18;
  localparam int FRAC  = 11;
  localparam int ACC_W = 2 * WIDTH + 2;

  typedef logic signed [WIDTH-1:0] fx_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam fx_t  ONE    = fx_t'(1 << FRAC);
  localparam acc_t FX_MAX = acc_t'((1 << (WIDTH - 1)) - 1);
  localparam acc_t FX_MIN = -FX_MAX - acc_t'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_X,
    ST_CALC,
    ST_OUTPUT,
    ST_FINISH
  } state_t;

  typedef struct packed {
    fx_t w_fx; fx_t w_fh; fx_t b_f;
    fx_t w_ix; fx_t w_ih; fx_t b_i;
    fx_t w_gx; fx_t w_gh; fx_t b_g;
    fx_t w_ox; fx_t w_oh; fx_t b_o;
  } lstm_w_t;

  function automatic fx_t sat(input acc_t v);
    if (v > FX_MAX) return fx_t'(FX_MAX);
    if (v < FX_MIN) return fx_t'(FX_MIN);
    return fx_t'(v);
  endfunction

  function automatic fx_t hard_sigmoid(input fx_t z);
    acc_t t;
    t = (acc_t'(z) >>> 2) + acc_t'(ONE >>> 1);
    if (t < 0) return '0;
    if (t > acc_t'(ONE)) return ONE;
    return fx_t'(t);
  endfunction

  function automatic fx_t hard_tanh(input fx_t z);
    if (z > ONE) return ONE;
    if (z < -ONE) return -ONE;
    return z;
  endfunction
endpackage

// File: rtl/lstm_cell_step.sv
// Three-stage scalar LSTM datapath: pre-activations, activations, then the c/h update.
// Each stage registers only when en is high and stage selects it; h_new/c_new hold otherwise.
module lstm_cell_step
  import lstm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] stage,
  input  fx_t        x,
  input  fx_t        h,
  input  fx_t        c,
  input  lstm_w_t    w,
  output fx_t        h_new,
  output fx_t        c_new
);
  // gate order in z/act arrays: f, i, g, o
  fx_t z_q   [4];
  fx_t z_d   [4];
  fx_t act_q [4];
  fx_t act_d [4];
  fx_t pre   [4];
  fx_t h_new_q, h_new_d, c_new_q, c_new_d;
  fx_t c_calc, h_calc;

  function automatic fx_t preact(input fx_t wx, input fx_t wh, input fx_t b,
                                 input fx_t xv, input fx_t hv);
    acc_t s;
    s = acc_t'(wx) * acc_t'(xv) + acc_t'(wh) * acc_t'(hv);
    return sat(acc_t'(sat(s >>> FRAC)) + acc_t'(b));
  endfunction

  always_comb begin
    pre[0] = preact(w.w_fx, w.w_fh, w.b_f, x, h);
    pre[1] = preact(w.w_ix, w.w_ih, w.b_i, x, h);
    pre[2] = preact(w.w_gx, w.w_gh, w.b_g, x, h);
    pre[3] = preact(w.w_ox, w.w_oh, w.b_o, x, h);
    c_calc = sat((acc_t'(act_q[0]) * acc_t'(c) + acc_t'(act_q[1]) * acc_t'(act_q[2])) >>> FRAC);
    h_calc = sat((acc_t'(act_q[3]) * acc_t'(hard_tanh(c_calc))) >>> FRAC);
    z_d     = z_q;
    act_d   = act_q;
    h_new_d = h_new_q;
    c_new_d = c_new_q;
    if (en) begin
      case (stage)
        2'd0: z_d = pre;
        2'd1: begin
          act_d[0] = hard_sigmoid(z_q[0]);
          act_d[1] = hard_sigmoid(z_q[1]);
          act_d[2] = hard_tanh(z_q[2]);
          act_d[3] = hard_sigmoid(z_q[3]);
        end
        2'd2: begin
          c_new_d = c_calc;
          h_new_d = h_calc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q     <= '{default: '0};
      act_q   <= '{default: '0};
      h_new_q <= '0;
      c_new_q <= '0;
    end else begin
      z_q     <= z_d;
      act_q   <= act_d;
      h_new_q <= h_new_d;
      c_new_q <= c_new_d;
    end
  end

  assign h_new = h_new_q;
  assign c_new = c_new_q;
endmodule

// File: rtl/lstm_seq_core.sv
// Sequencer for the scalar LSTM cell: handshakes, step counting and h/c retained across sequences.
//   state     | meaning
//   ST_IDLE   | waiting for start; retained h/c hold the last sequence's result
//   ST_WAIT_X | x_ready high, waiting for the next input sample
//   ST_CALC   | three datapath stages, sequenced by cnt_q
//   ST_OUTPUT | out_valid high until the consumer accepts the step result
//   ST_FINISH | one-cycle done pulse
module lstm_seq_core
  import lstm_pkg::*;
#(
  parameter int SEQ_LEN_MAX = 16,
  parameter int LEN_W       = $clog2(SEQ_LEN_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             keep_state,
  input  logic [WIDTH-1:0] h_init,
  input  logic [WIDTH-1:0] c_init,
  input  logic [WIDTH-1:0] W_fx,
  input  logic [WIDTH-1:0] W_fh,
  input  logic [WIDTH-1:0] b_f,
  input  logic [WIDTH-1:0] W_ix,
  input  logic [WIDTH-1:0] W_ih,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] W_gx,
  input  logic [WIDTH-1:0] W_gh,
  input  logic [WIDTH-1:0] b_g,
  input  logic [WIDTH-1:0] W_ox,
  input  logic [WIDTH-1:0] W_oh,
  input  logic [WIDTH-1:0] b_o,
  input  logic             x_valid,
  input  logic [WIDTH-1:0] x_data,
  output logic             x_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] h_out,
  output logic [WIDTH-1:0] c_out,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0] step_q, step_d, len_q, len_d;
  lstm_w_t          w_q, w_d;
  fx_t              x_q, x_d, h_q, h_d, c_q, c_d;
  fx_t              h_new, c_new;
  logic             cell_en, last_step;

  lstm_cell_step u_cell (
    .clk   (clk),
    .rst   (rst),
    .en    (cell_en),
    .stage (cnt_q),
    .x     (x_q),
    .h     (h_q),
    .c     (c_q),
    .w     (w_q),
    .h_new (h_new),
    .c_new (c_new)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    len_d     = len_q;
    w_d       = w_q;
    x_d       = x_q;
    h_d       = h_q;
    c_d       = c_q;
    x_ready   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    cell_en   = 1'b0;
    last_step = (step_q == len_q - LEN_W'(1));
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_len == '0) begin
            state_d = ST_FINISH;
          end else begin
            len_d = (cfg_len > LEN_W'(SEQ_LEN_MAX)) ? LEN_W'(SEQ_LEN_MAX) : cfg_len;
            w_d = '{w_fx: W_fx, w_fh: W_fh, b_f: b_f,
                    w_ix: W_ix, w_ih: W_ih, b_i: b_i,
                    w_gx: W_gx, w_gh: W_gh, b_g: b_g,
                    w_ox: W_ox, w_oh: W_oh, b_o: b_o};
            if (!keep_state) begin
              h_d = h_init;
              c_d = c_init;
            end
            step_d  = '0;
            state_d = ST_WAIT_X;
          end
        end
      end
      ST_WAIT_X: begin
        x_ready = 1'b1;
        if (x_valid) begin
          x_d     = x_data;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        cell_en = 1'b1;
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd2) begin
          cnt_d   = '0;
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        out_valid = 1'b1;
        out_last  = last_step;
        if (out_ready) begin
          // committing here keeps the working state equal to the last accepted result
          h_d = h_new;
          c_d = c_new;
          if (last_step) begin
            state_d = ST_FINISH;
          end else begin
            step_d  = step_q + LEN_W'(1);
            state_d = ST_WAIT_X;
          end
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      w_q     <= '0;
      x_q     <= '0;
      h_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      len_q   <= len_d;
      w_q     <= w_d;
      x_q     <= x_d;
      h_q     <= h_d;
      c_q     <= c_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign h_out = h_new;
  assign c_out = c_new;
endmodule

// File: tb/tb_lstm_seq_core.sv
// Bench for lstm_seq_core: an arithmetic LSTM reference model feeds an expected-result queue
// that a negedge monitor checks against every valid output, plus literal pins on known cases.
module tb_lstm_seq_core;
  localparam int W  = 18;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          keep_state = 1'b0;
  logic [W-1:0]  h_init = '0, c_init = '0;
  logic [W-1:0]  wp [12];
  logic          x_valid = 1'b0;
  logic [W-1:0]  x_data = '0;
  logic          x_ready, out_valid, out_last, busy, done;
  logic          out_ready = 1'b1;
  logic [W-1:0]  h_out, c_out;

  always #5 clk = ~clk;

  lstm_seq_core dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .keep_state(keep_state),
    .h_init(h_init), .c_init(c_init),
    .W_fx(wp[0]), .W_fh(wp[1]), .b_f(wp[2]),
    .W_ix(wp[3]), .W_ih(wp[4]), .b_i(wp[5]),
    .W_gx(wp[6]), .W_gh(wp[7]), .b_g(wp[8]),
    .W_ox(wp[9]), .W_oh(wp[10]), .b_o(wp[11]),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .out_valid(out_valid), .out_ready(out_ready), .h_out(h_out), .c_out(c_out),
    .out_last(out_last), .busy(busy), .done(done)
  );

  typedef struct { longint h; longint c; bit last; } res_t;
  res_t   exp_q [$];
  res_t   obs_q [$];
  longint mw [12];
  longint m_h = 0, m_c = 0;
  int     n_vec = 0, n_err = 0;
  int     cyc = 0, acc_cyc = 0;
  bit     done_due = 1'b0, prev_ov = 1'b0;

  function automatic longint clip(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction
  function automatic longint satw(input longint v);
    return clip(v, -131072, 131071);
  endfunction
  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: one LSTM time step in plain integer arithmetic on the model's h/c.
  task automatic model_step(input longint x, output longint hn, output longint cn);
    longint z [4];
    longint f, i, g, o;
    for (int k = 0; k < 4; k++)
      z[k] = satw(satw((mw[3*k] * x + mw[3*k+1] * m_h) >>> 11) + mw[3*k+2]);
    f  = clip((z[0] >>> 2) + 1024, 0, 2048);
    i  = clip((z[1] >>> 2) + 1024, 0, 2048);
    g  = clip(z[2], -2048, 2048);
    o  = clip((z[3] >>> 2) + 1024, 0, 2048);
    cn = satw((f * m_c + i * g) >>> 11);
    hn = satw((o * clip(cn, -2048, 2048)) >>> 11);
    m_h = hn;
    m_c = cn;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst && x_valid && x_ready) acc_cyc = cyc;
  end

  always @(negedge clk) begin : cmp
    res_t e;
    res_t o;
    if (rst) begin
      done_due = 1'b0;
      prev_ov  = 1'b0;
    end else begin
      chk("done", longint'(done), longint'(done_due));
      done_due = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q[0];
          chk("h_out", sx(h_out), e.h);
          chk("c_out", sx(c_out), e.c);
          chk("out_last", longint'(out_last), longint'(e.last));
          chk("x_ready_in_output", longint'(x_ready), 0);
          if (!prev_ov) chk("latency", longint'(cyc - acc_cyc), 3);
          if (out_ready) begin
            o.h = sx(h_out); o.c = sx(c_out); o.last = out_last;
            obs_q.push_back(o);
            void'(exp_q.pop_front());
            if (e.last) done_due = 1'b1;
          end
        end
      end
      if (start && cfg_len == '0) done_due = 1'b1;
      prev_ov = out_valid;
    end
  end

  task automatic hold_out();
    bit seen = 1'b0;
    logic [W-1:0] h0, c0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("bp_out_valid_seen", longint'(seen), 1);
    h0 = h_out;
    c0 = c_out;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_valid_held", longint'(out_valid), 1);
      chk("bp_h_stable", sx(h_out), sx(h0));
      chk("bp_c_stable", sx(c_out), sx(c0));
      chk("bp_x_ready_low", longint'(x_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
  endtask

  task automatic drive_steps(input int n, input longint xs [$], input int abort_at, output bit aborted);
    bit got;
    longint xv;
    aborted = 1'b0;
    for (int s = 0; s < n; s++) begin
      xv = xs[s];
      x_valid = 1'b1;
      x_data  = xv[W-1:0];
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge clk);
        got = x_ready;
        @(posedge clk);
        #1;
      end
      if (!got) begin
        chk("x_accept_timeout", 0, 1);
        break;
      end
      if (s == abort_at) begin
        rst = 1'b1;
        x_valid = 1'b0;
        exp_q.delete();
        m_h = 0;
        m_c = 0;
        @(posedge clk);
        #1;
        chk("abort_out_valid", longint'(out_valid), 0);
        chk("abort_x_ready", longint'(x_ready), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_done", longint'(done), 0);
        chk("abort_out_last", longint'(out_last), 0);
        chk("abort_h", sx(h_out), 0);
        chk("abort_c", sx(c_out), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        aborted = 1'b1;
        return;
      end
      if (s == 0) begin
        start = 1'b1;
        cfg_len = LW'(3);
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    x_valid = 1'b0;
  endtask

  task automatic run_seq(input int len, input bit keep, input longint hi, input longint ci,
                         input longint xs [$], input int abort_at, input bit bp);
    int n;
    bit ab, got;
    longint hn, cn, tmp;
    res_t r;
    n = (len > 16) ? 16 : len;
    if (n > 0) begin
      if (!keep) begin m_h = hi; m_c = ci; end
      for (int s = 0; s < n; s++) begin
        model_step(xs[s], hn, cn);
        r.h = hn; r.c = cn; r.last = (s == n - 1);
        exp_q.push_back(r);
      end
    end
    obs_q.delete();
    for (int k = 0; k < 12; k++) begin
      tmp = mw[k];
      wp[k] = tmp[W-1:0];
    end
    h_init = hi[W-1:0];
    c_init = ci[W-1:0];
    keep_state = keep;
    cfg_len = LW'(len);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 12; k++) wp[k] = W'($urandom);
    h_init = W'($urandom);
    c_init = W'($urandom);
    fork
      drive_steps(n, xs, abort_at, ab);
      begin if (bp) hold_out(); end
    join
    if (!ab) begin
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge clk);
        got = done;
      end
      chk("done_seen", longint'(got), 1);
      chk("queue_drained", longint'(exp_q.size()), 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pin(input int idx, input longint h, input longint c);
    if (obs_q.size() > idx) begin
      chk("pin_h", obs_q[idx].h, h);
      chk("pin_c", obs_q[idx].c, c);
    end else begin
      chk("pin_missing", longint'(obs_q.size()), longint'(idx + 1));
    end
  endtask

  task automatic zero_w();
    for (int k = 0; k < 12; k++) mw[k] = 0;
  endtask

  task automatic rand_w(input longint span);
    for (int k = 0; k < 12; k++) mw[k] = longint'($urandom_range(0, 2 * span - 1)) - span;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint xs [$];
    zero_w();
    for (int k = 0; k < 12; k++) wp[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x_ready", longint'(x_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_last", longint'(out_last), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_h_out", sx(h_out), 0);
    chk("rst_c_out", sx(c_out), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // zero weights, c decays by half each step
    xs.delete(); xs.push_back(777); xs.push_back(-555);
    run_seq(2, 1'b0, 0, 2048, xs, -1, 1'b0);
    pin(0, 512, 1024);
    pin(1, 256, 512);
    chk("model_pin_h", m_h, 256);

    // b_g = 1.0 drives g to 1.0
    zero_w(); mw[8] = 2048;
    xs.delete(); xs.push_back(100); xs.push_back(200);
    run_seq(2, 1'b0, 0, 0, xs, -1, 1'b0);
    pin(0, 512, 1024);
    pin(1, 768, 1536);

    // continuation from retained state
    xs.delete(); xs.push_back(5);
    run_seq(1, 1'b1, 0, 0, xs, -1, 1'b0);
    pin(0, 896, 1792);
    chk("model_pin_c", m_c, 1792);

    // pre-activation saturation, no sign flip
    zero_w(); mw[6] = 63488;
    xs.delete(); xs.push_back(63488);
    run_seq(1, 1'b0, 0, 0, xs, -1, 1'b0);
    pin(0, 512, 1024);

    // backpressure on step 0
    zero_w();
    out_ready = 1'b0;
    xs.delete(); xs.push_back(1); xs.push_back(2);
    run_seq(2, 1'b0, 0, 2048, xs, -1, 1'b1);
    pin(0, 512, 1024);
    pin(1, 256, 512);

    // zero-length sequence
    run_seq(0, 1'b0, 0, 0, xs, -1, 1'b0);
    chk("len0_no_outputs", longint'(obs_q.size()), 0);

    // reset during CALC of step 1, then continue from cleared state
    rand_w(4096);
    xs.delete(); for (int s = 0; s < 4; s++) xs.push_back(longint'($urandom_range(0, 8191)) - 4096);
    run_seq(4, 1'b0, 300, -400, xs, 1, 1'b0);
    zero_w(); mw[8] = 2048;
    xs.delete(); xs.push_back(9);
    run_seq(1, 1'b1, 1000, 1000, xs, -1, 1'b0);
    pin(0, 512, 1024);

    // over-length request clamps to 16 steps
    rand_w(4096);
    xs.delete(); for (int s = 0; s < 16; s++) xs.push_back(longint'($urandom_range(0, 32767)) - 16384);
    run_seq(20, 1'b0, 1500, -2500, xs, -1, 1'b0);
    chk("clamp_steps", longint'(obs_q.size()), 16);

    // chained full-range runs exercise saturation and negative floor shifts
    rand_w(131072);
    xs.delete(); for (int s = 0; s < 3; s++) xs.push_back(longint'($urandom_range(0, 262143)) - 131072);
    run_seq(3, 1'b0, -3000, 3000, xs, -1, 1'b0);
    xs.delete(); for (int s = 0; s < 5; s++) xs.push_back(longint'($urandom_range(0, 262143)) - 131072);
    run_seq(5, 1'b1, 0, 0, xs, -1, 1'b0);
    chk("chain_steps", longint'(obs_q.size()), 5);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
